// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } dmem_state_t;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size comes from funct3[1:0]; reserved encodings behave as word.
    function automatic logic is_aligned(input logic [1:0] addr_lo, input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 1'b1;
            2'b01:   return ~addr_lo[0];
            default: return (addr_lo == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Selects the addressed byte/halfword lane of a bus read word and extends it.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = bus_rdata[{addr, 3'b000} +: 8];
    assign half_lane = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    // Extend the selected lane according to size and signedness.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves data unassigned (no latch).
        data = bus_rdata;
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data = {24'h0, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data = {16'h0, half_lane};
            F3_W:    data = bus_rdata;
            default: data = bus_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// MEM-stage bridge from the pipeline's zero-latency memory port to a
// valid/ready bus: formats loads and stores, stalls while an access is
// outstanding, and reports misaligned accesses and bus timeouts.
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    // Counter value seen in the last REQ cycle before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    dmem_state_t state;
    logic [7:0]  cnt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;

    logic        req_any;
    logic        aligned;
    logic        accept;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] load_data;

    assign req_any = req_read | req_write;
    assign aligned = is_aligned(req_addr[1:0], req_funct3);
    assign accept  = (state == IDLE) & req_any & aligned;

    // The pipeline sees stall/misaligned combinationally; both are held low while in reset.
    assign stall      = rst & ((state == REQ) | accept);
    assign misaligned = rst & (state == IDLE) & req_any & ~aligned;

    // Replicate store data across lanes and build the byte strobes.
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'hF;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'hF;
            end
        endcase
    end

    dmem_load_align u_load_align (
        .bus_rdata (bus_rdata),
        .addr      (addr_lo_q),
        .funct3    (funct3_q),
        .data      (load_data)
    );

    // Access sequencer: latches the request, drives the bus, captures the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            rdata       <= '0;
            bus_timeout <= 1'b0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_wstrb   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        cnt       <= '0;
                        addr_lo_q <= req_addr[1:0];
                        funct3_q  <= req_funct3;
                        bus_valid <= 1'b1;
                        bus_we    <= req_write;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_wdata <= st_wdata;
                        bus_wstrb <= req_write ? st_wstrb : 4'h0;
                    end
                end
                REQ: begin
                    // A response in the final allowed cycle still wins over the timeout.
                    if (bus_ready) begin
                        state     <= DONE;
                        bus_valid <= 1'b0;
                        rdata     <= bus_we ? 32'h0 : load_data;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        bus_valid   <= 1'b0;
                        rdata       <= 32'h0;
                        bus_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // Inputs still show the completed request; ignore them this cycle.
                    state       <= IDLE;
                    rdata       <= 32'h0;
                    bus_timeout <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge against a byte-lane reference model.
module tb_dmem_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic [31:0] rdata;
    logic        stall, misaligned, bus_timeout;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_funct3  (req_funct3),
        .rdata       (rdata),
        .stall       (stall),
        .misaligned  (misaligned),
        .bus_timeout (bus_timeout),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
        int     size;
        longint full, v;
        size = size_of(f3);
        if (size == 4) return w;
        full = longint'(1) << (8 * size);
        v = (longint'(w) >> (8 * int'(a))) % full;
        if (f3[2] == 1'b0 && v >= full / 2) v = v - full;
        return v[31:0];
    endfunction

    // ---------------- driving helpers ----------------
    task automatic drive_idle();
        req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        bus_ready = 0; bus_rdata = $urandom;
    endtask

    task automatic idle_cycle(input string name);
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (stall !== 1'b0 || bus_valid !== 1'b0 || rdata !== 32'h0 || bus_timeout !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: stall=%b valid=%b rdata=%h timeout=%b mis=%b, required all 0",
                     name, stall, bus_valid, rdata, bus_timeout, misaligned);
        end
    endtask

    // One complete aligned access with `waits` wait states; waits >= TO means no response.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input int waits, input logic [31:0] rword, input string name);
        int          size, a, stall_cnt, valid_cnt, req_cycles;
        bit          timed_out;
        logic [31:0] exp_rdata, exp_wdata, exp_addr;
        logic [3:0]  exp_strb;

        size      = size_of(f3);
        a         = int'(addr[1:0]);
        timed_out = (waits >= TO);
        exp_addr  = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
            exp_wdata[8*i +: 8] = 8'((wd >> (8 * (i % size))) & 32'hFF);
            exp_strb[i]         = wr && (i >= a) && (i < a + size);
        end
        exp_rdata  = (wr || timed_out) ? 32'h0 : model_load(rword, addr[1:0], f3);
        req_cycles = timed_out ? TO : waits + 1;
        stall_cnt  = 0;
        valid_cnt  = 0;

        // IDLE detect cycle
        @(negedge clk);
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        bus_ready = 0; bus_rdata = $urandom;
        #1;
        if (stall === 1'b1) stall_cnt++;
        checks++;
        if (bus_valid !== 1'b0 || misaligned !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: valid=%b mis=%b, required 0 0", name, bus_valid, misaligned);
        end

        // REQ cycles
        for (int k = 0; k < req_cycles; k++) begin
            @(negedge clk);
            bus_ready = !timed_out && (k == waits);
            bus_rdata = bus_ready ? rword : $urandom;
            #1;
            if (stall === 1'b1) stall_cnt++;
            if (bus_valid === 1'b1) valid_cnt++;
            checks++;
            if (bus_addr !== exp_addr || bus_we !== wr || bus_wstrb !== exp_strb || (wr && bus_wdata !== exp_wdata)) begin
                errors++;
                $display("FAIL %s payload cyc%0d: addr=%h we=%b strb=%b wdata=%h, required %h %b %b %h",
                         name, k, bus_addr, bus_we, bus_wstrb, bus_wdata, exp_addr, wr, exp_strb, exp_wdata);
            end
        end

        // DONE cycle
        @(negedge clk);
        bus_ready = 0; bus_rdata = $urandom;
        #1;
        checks++;
        if (stall !== 1'b0 || bus_valid !== 1'b0 || rdata !== exp_rdata || bus_timeout !== timed_out) begin
            errors++;
            $display("FAIL %s done: stall=%b valid=%b rdata=%h timeout=%b, required 0 0 %h %b",
                     name, stall, bus_valid, rdata, bus_timeout, exp_rdata, timed_out);
        end
        checks++;
        if (stall_cnt != req_cycles + 1 || valid_cnt != req_cycles) begin
            errors++;
            $display("FAIL %s timing: stall cycles=%0d valid cycles=%0d, required %0d %0d",
                     name, stall_cnt, valid_cnt, req_cycles + 1, req_cycles);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        req_read = 1; req_addr = 32'h100; req_funct3 = 3'b010;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stall !== 0 || misaligned !== 0 || bus_timeout !== 0 || bus_valid !== 0 || bus_we !== 0 ||
            bus_addr !== 0 || bus_wdata !== 0 || bus_wstrb !== 0 || rdata !== 0) begin
            errors++;
            $display("FAIL reset: stall=%b mis=%b to=%b valid=%b we=%b addr=%h wdata=%h strb=%b rdata=%h, required all 0",
                     stall, misaligned, bus_timeout, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb, rdata);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        idle_cycle("post_reset");
    endtask

    task automatic test_load_word();
        run_access(1, 0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, "lw_zero_wait");
    endtask

    task automatic test_load_formats();
        run_access(1, 0, 32'h103, 32'h0, 3'b000, 0, 32'h80123456, "lb");
        run_access(1, 0, 32'h103, 32'h0, 3'b100, 1, 32'h80123456, "lbu");
        run_access(1, 0, 32'h102, 32'h0, 3'b101, 2, 32'h80123456, "lhu");
        run_access(1, 0, 32'h102, 32'h0, 3'b001, 0, 32'h80123456, "lh");
        idle_cycle("after_loads");
    endtask

    task automatic test_store_half();
        run_access(0, 1, 32'h206, 32'h0000ABCD, 3'b001, 3, 32'h0, "sh_3wait");
        run_access(0, 1, 32'h201, 32'h123456A5, 3'b000, 1, 32'h0, "sb");
        run_access(1, 1, 32'h208, 32'hCAFEF00D, 3'b010, 0, 32'h5555AAAA, "rw_write_wins");
        idle_cycle("after_stores");
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs [4] = '{32'h102, 32'h103, 32'h301, 32'h401};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_idle();
            req_read = (i != 3); req_write = (i == 3);
            req_addr = addrs[i]; req_funct3 = f3s[i];
            #1;
            checks++;
            if (misaligned !== 1'b1 || stall !== 1'b0 || bus_valid !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_%0d: mis=%b stall=%b valid=%b, required 1 0 0", i, misaligned, stall, bus_valid);
            end
            idle_cycle("misaligned_after");
        end
    endtask

    task automatic test_timeout();
        run_access(1, 0, 32'h400, 32'h0, 3'b010, TO, 32'h0, "timeout");
        idle_cycle("after_timeout");
        run_access(1, 0, 32'h404, 32'h0, 3'b010, TO - 1, 32'h13579BDF, "ready_last_cycle");
        idle_cycle("after_last_cycle");
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        drive_idle();
        req_read = 1; req_addr = 32'h500; req_funct3 = 3'b010;
        @(negedge clk);   // first REQ cycle
        @(negedge clk);   // second REQ cycle
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus_valid !== 1'b0 || stall !== 1'b0 || bus_timeout !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b stall=%b to=%b rdata=%h, required 0 0 0 0", bus_valid, stall, bus_timeout, rdata);
        end
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
        idle_cycle("reset_mid_release");
        run_access(1, 0, 32'h504, 32'h0, 3'b010, 1, 32'h0BADF00D, "lw_after_reset");
        idle_cycle("after_reset_lw");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] addr;
            int          kind;
            f3   = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 2);
            addr = $urandom & ~(32'(size_of(f3)) - 32'd1);
            run_access(kind != 1, kind != 0, addr, $urandom, f3, $urandom_range(0, TO), $urandom, "random");
            if ($urandom_range(0, 3) == 0) idle_cycle("random_gap");
        end
        idle_cycle("after_random");
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_load_word();
        test_load_formats();
        test_store_half();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
